// File: rtl/sram22_port_ctrl.sv
// Request/response front end for a 1-cycle-latency single-port SRAM macro.
// Reads are tracked through a small response FIFO; writes produce no response.
module sram22_port_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WMASK_WIDTH = 1,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  // request channel
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  // response channel
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  // SRAM macro side
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  // status
  output logic                   busy
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic                  fire;
  logic                  pop;
  logic                  push;
  logic                  full;
  logic                  rd_pending_q, rd_pending_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW:0]         occupancy;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign rsp_valid = (count_q != '0);
  assign rsp_rdata = fifo_mem[rd_ptr_q];
  assign pop       = rsp_valid & rsp_ready;

  // A read in flight already owns a FIFO slot, so count it against capacity.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, rd_pending_q};
  assign req_ready = !rst && ((occupancy < (CntW + 1)'(RSP_DEPTH)) || pop);
  assign fire      = req_valid & req_ready;

  assign sram_we    = fire & req_we;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;
  assign sram_wmask = req_wmask;

  // sram_dout holds the fired read's data exactly one edge after the fire.
  assign push = rd_pending_q;
  assign full = (count_q == CntW'(RSP_DEPTH));
  assign busy = rd_pending_q | rsp_valid;

  always_comb begin
    rd_pending_d = fire & ~req_we;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Payload storage needs no reset; validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= sram_dout;
  end

`ifndef SYNTHESIS
  push_never_overflows: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));
`endif

endmodule

// File: doc/sram22_port_ctrl.md
SRAM22_PORT_CTRL -- requirements
Module: sram22_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, word address width.
REQ-003 SHALL have parameter WMASK_WIDTH, default 1, write-mask width.
REQ-004 SHALL have parameter RSP_DEPTH, default 2, response FIFO entries (>=2).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  clock; rst  input  1  reset.
REQ-006 SHALL have ports req_valid input 1, request valid; req_ready output 1, request accepted when high with req_valid.
REQ-007 SHALL have ports req_we input 1, request is a write; req_addr input ADDR_WIDTH, word address.
REQ-008 SHALL have ports req_wdata input DATA_WIDTH, write data; req_wmask input WMASK_WIDTH, write mask.
REQ-009 SHALL have ports rsp_valid output 1, read data valid; rsp_ready input 1, consumer accepts; rsp_rdata output DATA_WIDTH, read data.
REQ-010 SHALL have SRAM-side ports sram_we output 1, sram_wmask output WMASK_WIDTH, sram_addr output ADDR_WIDTH, sram_din output DATA_WIDTH, and sram_dout input DATA_WIDTH.
REQ-011 SHALL have port busy output 1, high while any read is in flight or buffered.

Function
REQ-012 SHALL define fire = req_valid & req_ready and pop = rsp_valid & rsp_ready.
REQ-013 SHALL drive sram_addr = req_addr, sram_din = req_wdata and sram_wmask = req_wmask combinationally.
REQ-014 SHALL drive sram_we = fire & req_we, so the SRAM captures the operation on the same clk edge as the handshake.
REQ-015 SHALL treat every non-write cycle as an SRAM read that overwrites sram_dout; only fired reads are tracked.
REQ-016 SHALL set a registered rd_pending flag at edge N when a read fires, clear it at edge N+1 unless another read fires.
REQ-017 SHALL push sram_dout into the response FIFO at edge N+1 when rd_pending is high (SRAM read latency = 1 cycle).
REQ-018 SHALL give rsp_valid at earliest in the cycle after edge N+1, i.e. 2-cycle request-to-response latency.
REQ-019 SHALL produce no response for writes; a write with req_wmask = 0 fires normally and changes no memory.
REQ-020 SHALL drive req_ready = !rst & ((count + rd_pending < RSP_DEPTH) | pop), where count is FIFO occupancy, for reads and writes alike.
REQ-021 SHALL never overflow the FIFO; a push while full is a design error flagged by a simulation assertion.
REQ-022 SHALL sustain one read per cycle with rsp_ready held high, with no bubbles.
REQ-023 SHALL handle a simultaneous push and pop in one cycle with count unchanged and data order preserved (FIFO order = request order).
REQ-024 SHALL hold rsp_rdata stable while rsp_valid is high and rsp_ready is low.
REQ-025 SHALL return, for a read of address A in the cycle after a write to A, the newly written data.
REQ-026 SHALL wrap the FIFO read and write pointers modulo RSP_DEPTH.
REQ-027 SHALL drive busy = rd_pending | (count != 0).

Reset
REQ-028 SHALL, while rst is high, force req_ready = 0, sram_we = 0, rsp_valid = 0, busy = 0, count = 0, rd_pending = 0 and pointers = 0.
REQ-029 SHALL discard any in-flight read or buffered responses on reset mid-operation, producing no response after reset release.
REQ-030 SHALL raise req_ready in the first cycle after rst deasserts.

Verification
REQ-031 SHALL be tested with: write 0xDEADBEEF to addr 5 with wmask=1, then read addr 5 -> rsp_rdata = 0xDEADBEEF, 2 cycles after the read fires.
REQ-032 SHALL be tested with: reads of addr 0..7 back-to-back with rsp_ready=1 -> 8 responses on 8 consecutive cycles, in order, req_ready never low.
REQ-033 SHALL be tested with: rsp_ready=0 and 4 reads issued -> exactly 2 accepted, req_ready=0 afterwards; then rsp_ready=1 -> both drain in order and req_ready returns to 1.
REQ-034 SHALL be tested with: write 0x12345678 with wmask=0 to addr 3 previously holding 0 -> a read of addr 3 returns 0x00000000 and no response follows the write.
REQ-035 SHALL be tested with: rst asserted one cycle after a read fires -> rsp_valid stays 0 through and after reset, and busy = 0.
REQ-036 SHALL be tested with: write addr 9 = 0xA5A5A5A5 immediately followed by a read of addr 9 -> 0xA5A5A5A5 returned.
